booth_r4_seq_mul: RTL and testbench



---
 rtl/booth_pkg.sv | 40 ++++
 rtl/booth_r4_digit.sv | 31 +++
 rtl/booth_r4_seq_mul.sv | 140 ++++++++++++++
 tb/tb_booth_r4_seq_mul.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared sizing helpers, Booth digit select encoding and FSM state codes.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package booth_pkg;

  // Multiplier width after extension: B_W+1 rounded up to an even count.
  function automatic int calc_bx_w(input int b_w);
    return (b_w + 1) + ((b_w + 1) % 2);
  endfunction

  // One radix-4 digit per pair of extended multiplier bits.
  function automatic int calc_ndig(input int b_w);
    return calc_bx_w(b_w) / 2;
  endfunction

  function automatic int calc_p_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Bit positions inside the 3-bit digit select vector.
  localparam int SEL_ONE = 0;  // |d| == 1
  localparam int SEL_TWO = 1;  // |d| == 2
  localparam int SEL_NEG = 2;  // d < 0

  // Window {b[2k+1], b[2k], b[2k-1]} -> select vector. 111 and 000 give d=0.
  function automatic logic [2:0] booth_sel(input logic [2:0] win);
    logic [2:0] sel;
    sel          = '0;
    sel[SEL_ONE] = win[1] ^ win[0];
    sel[SEL_TWO] = (win == 3'b011) || (win == 3'b100);
    sel[SEL_NEG] = win[2] & ~(win[1] & win[0]);
    return sel;
  endfunction

  // FSM state codes.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/booth_r4_digit.sv
// One radix-4 Booth digit: window + multiplicand -> one's-complement partial product and neg bit.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int A_W = 12
) (
  input  logic [2:0]   win_i,
  input  logic [A_W-1:0] a_i,
  output logic [A_W:0] pp_o,
  output logic         neg_o
);

  logic [2:0]   sel;
  logic [A_W:0] mag;

  // Select |d|*a on A_W+1 bits, then invert for negative digits; the +1 is added by the caller.
  always_comb begin
    sel = booth_sel(win_i);
    mag = '0;
    if (sel[SEL_ONE]) begin
      mag = {a_i[A_W-1], a_i};
    end else if (sel[SEL_TWO]) begin
      mag = {a_i, 1'b0};
    end
    pp_o  = sel[SEL_NEG] ? ~mag : mag;
    neg_o = sel[SEL_NEG];
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier, one digit per clock, optional OR-merged low columns.
// Latency: out_valid in the NDIG+1'th cycle counting the accept cycle; one result per NDIG+2 cycles.
// Backpressure: DONE holds product/out_valid until out_ready; in_valid is ignored while busy.
module booth_r4_seq_mul
  import booth_pkg::*;
#(
  parameter int A_W      = 12,
  parameter int B_W      = 8,
  parameter int APPROX_P = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               b_signed,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] product,
  output logic               busy
);

  localparam int BX_W = calc_bx_w(B_W);
  localparam int NDIG = calc_ndig(B_W);
  localparam int P_W  = calc_p_w(A_W, B_W);
  localparam int K_W  = $clog2(NDIG + 1);
  localparam logic [K_W-1:0] K_LAST  = K_W'(NDIG - 1);
  // Columns below APPROX_P are the approximate region; a zero APPROX_P leaves it empty.
  localparam logic [P_W-1:0] LO_MASK = ~({P_W{1'b1}} << APPROX_P);
  localparam logic [P_W-1:0] HI_MASK = ~LO_MASK;

  logic [1:0]      state_q, state_d;
  logic [K_W-1:0]  k_q, k_d;
  logic [A_W-1:0]  a_q, a_d;
  logic [BX_W-1:0] bx_q, bx_d;
  logic            approx_q, approx_d;
  logic [P_W-1:0]  acc_q, acc_d;
  logic [P_W-1:0]  prod_q, prod_d;

  logic [BX_W:0]   bxe;
  logic [K_W:0]    shamt;
  logic [2:0]      win;
  logic [A_W:0]    pp;
  logic signed [A_W:0] pp_s;
  logic            neg;
  logic [P_W-1:0]  ppw, negw, exact_sum, approx_sum, acc_step;

  // The appended zero is the implicit b[-1]; shamt is the digit weight 2k.
  assign bxe   = {bx_q, 1'b0};
  assign shamt = {k_q, 1'b0};
  assign win   = bxe[shamt +: 3];
  assign pp_s  = pp;

  booth_r4_digit #(.A_W(A_W)) u_digit (
    .win_i (win),
    .a_i   (a_q),
    .pp_o  (pp),
    .neg_o (neg)
  );

  // Weight the partial product by 2^(2k) and form both exact and approximate accumulations.
  always_comb begin
    ppw        = P_W'(pp_s) << shamt;
    negw       = {{(P_W-1){1'b0}}, neg} << shamt;
    exact_sum  = acc_q + ppw + negw;
    // Low columns are OR-merged; high columns add with no carry coming up from below.
    approx_sum = ((acc_q | ppw | negw) & LO_MASK)
               | (((acc_q & HI_MASK) + (ppw & HI_MASK) + (negw & HI_MASK)) & HI_MASK);
    acc_step   = approx_q ? approx_sum : exact_sum;
  end

  // Next-state: accept in IDLE, retire one digit per RUN cycle, hold in DONE until consumed.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    bx_d     = bx_q;
    approx_d = approx_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          bx_d     = {{(BX_W-B_W){b_signed & b[B_W-1]}}, b};
          approx_d = approx_en;
          acc_d    = '0;
          k_d      = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        k_d   = k_q + K_W'(1);
        if (k_q == K_LAST) begin
          prod_d  = acc_step;
          k_d     = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      a_q      <= '0;
      bx_q     <= '0;
      approx_q <= 1'b0;
      acc_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      bx_q     <= bx_d;
      approx_q <= approx_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign product   = prod_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Scoreboarded bench: directed spec cases, back-pressure, throughput, reset mid-run, random sweep.
// Latency: n/a.
// Backpressure: out_ready driven fixed or randomized by a single process.
module tb_booth_r4_seq_mul;

  localparam int AW   = 12;
  localparam int BW   = 8;
  localparam int PW   = AW + BW;
  localparam int NDIG = 5;
  localparam int AP   = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic          b_signed;
  logic          approx_en;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rnd_bp    = 0;
  bit fixed_rdy = 1;
  logic [PW-1:0] exp_q[$];

  booth_r4_seq_mul #(.A_W(AW), .B_W(BW), .APPROX_P(AP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_signed  (b_signed),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of out_ready; changes shortly after the rising edge.
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #2;
    out_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : fixed_rdy;
  end

  task automatic chk(input string nm, input longint act, input longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: product from the digit definition d = -2*b[2k+1] + b[2k] + b[2k-1].
  function automatic logic [PW-1:0] ref_prod(input logic [AW-1:0] ra, input logic [BW-1:0] rb,
                                             input bit bs, input bit ap);
    longint av, bv, acc, ppw, negw, lo, hi, pmask;
    int d, b0, b1, bm1;
    av = longint'($signed(ra));
    bv = bs ? longint'($signed(rb)) : longint'(rb);
    if (!ap) return PW'(av * bv);
    pmask = (longint'(1) << PW) - 1;
    acc = 0;
    for (int k = 0; k < NDIG; k++) begin
      b0  = int'((bv >>> (2 * k)) & 1);
      b1  = int'((bv >>> (2 * k + 1)) & 1);
      bm1 = (k == 0) ? 0 : int'((bv >>> (2 * k - 1)) & 1);
      d   = -2 * b1 + b0 + bm1;
      // One's-complement value of -|d|*a is -|d|*a - 1.
      ppw  = (d < 0) ? (-longint'(-d) * av - 1) : (longint'(d) * av);
      ppw  = (ppw * (longint'(1) << (2 * k))) & pmask;
      negw = (d < 0) ? (longint'(1) << (2 * k)) : 0;
      lo   = (acc | ppw | negw) & ((longint'(1) << AP) - 1);
      hi   = ((acc >> AP) + (ppw >> AP) + (negw >> AP)) & ((longint'(1) << (PW - AP)) - 1);
      acc  = (hi << AP) | lo;
    end
    return PW'(acc);
  endfunction

  // Monitor: every consumed result is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %0h with empty scoreboard", product);
      end else begin
        chk("product", product, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [AW-1:0] ta, input logic [BW-1:0] tbv, input bit bs,
                      input bit ap, input logic [PW-1:0] e, input bit do_push,
                      output int acc_cyc);
    int g;
    g = 0;
    acc_cyc = -1;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("send_wait_in_ready", in_ready, 1);
    if (!in_ready) return;
    a = ta; b = tbv; b_signed = bs; approx_en = ap; in_valid = 1'b1;
    if (do_push) exp_q.push_back(e);
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("drain_scoreboard", exp_q.size(), 0);
  endtask

  initial begin
    int c, t0, t1, t2, tdummy;
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;
    bit bs, ap;
    logic [AW-1:0] ca[4];
    logic [BW-1:0] cb[4];
    ca[0] = 12'h800; ca[1] = 12'h7FF; ca[2] = 12'h000; ca[3] = 12'hFFF;
    cb[0] = 8'h80;   cb[1] = 8'h7F;   cb[2] = 8'hFF;   cb[3] = 8'h00;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; b_signed = 1'b0; approx_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_product", product, 0);
    rst_n = 1'b1;

    // Exact unsigned max; out_valid must appear on the 6th cycle after presenting the operands.
    send(12'd2047, 8'd255, 1'b0, 1'b0, 20'h7F701, 1'b1, tdummy);
    c = 1;
    while (!out_valid && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("latency_cycles", c, NDIG + 1);
    drain();

    send(12'h800, 8'h80, 1'b1, 1'b0, 20'h40000, 1'b1, tdummy);
    send(12'd2047, 8'hFF, 1'b1, 1'b0, 20'hFF801, 1'b1, tdummy);
    send(12'd5, 8'd5, 1'b0, 1'b1, 20'h00015, 1'b1, tdummy);
    send(12'd5, 8'd5, 1'b0, 1'b0, 20'h00019, 1'b1, tdummy);
    drain();

    // Back-to-back throughput with the consumer always ready.
    send(12'd100, 8'd200, 1'b0, 1'b0, 20'd20000, 1'b1, t0);
    send(12'hF9C, 8'd3, 1'b1, 1'b0, 20'hFFED4, 1'b1, t1);
    send(12'd7, 8'hF9, 1'b1, 1'b0, 20'hFFFCF, 1'b1, t2);
    chk("throughput_0", t1 - t0, NDIG + 2);
    chk("throughput_1", t2 - t1, NDIG + 2);
    drain();

    // Back-pressure: result held 10 cycles while a stray in_valid is presented.
    fixed_rdy = 1'b0;
    send(12'd100, 8'd3, 1'b0, 1'b0, 20'd300, 1'b1, tdummy);
    c = 0;
    while (!out_valid && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("bp_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_product", product, 20'd300);
      chk("bp_in_ready", in_ready, 0);
      a = AW'($urandom); b = BW'($urandom); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    fixed_rdy = 1'b1;
    drain();
    repeat (12) @(negedge clk);
    chk("bp_no_ghost_valid", out_valid, 0);
    chk("bp_no_ghost_busy", busy, 0);

    // Reset in RUN cycle 2 discards the transaction and clears outputs at once.
    send(12'd1234, 8'd56, 1'b0, 1'b0, '0, 1'b0, tdummy);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(12'd3, 8'd7, 1'b0, 1'b0, 20'd21, 1'b1, tdummy);
    drain();

    // Random sweep: exact first, then approximate, with random consumer stalls.
    rnd_bp = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      ra = AW'($urandom);
      rb = BW'($urandom);
      bs = bit'($urandom_range(0, 1));
      ap = (i >= 1500);
      if ((i % 50) == 0) begin
        ra = ca[$urandom_range(0, 3)];
        rb = cb[$urandom_range(0, 3)];
      end
      send(ra, rb, bs, ap, ref_prod(ra, rb, bs, ap), 1'b1, tdummy);
    end
    rnd_bp = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
